// File: rtl/rc_servo_core_n_pkg.sv
// rtl/rc_servo_core_n_pkg.sv - shared constants and width helpers for the N-channel servo core
//
// Purpose: default timing constants, the centre-position function and the
//          counter width helpers used by rc_servo_core_n and rc_servo_chan.
// Ports:   none (package).
package rc_servo_pkg;

   localparam int DEF_NUM_CH       = 2;
   localparam int DEF_TICK_DIV     = 50;
   localparam int DEF_PERIOD_US    = 20000;
   localparam int DEF_PULSE_MIN_US = 1000;
   localparam int DEF_PULSE_MAX_US = 2000;
   localparam int DEF_STEP_US      = 4;
   localparam int DEF_SYNC_STAGES  = 2;

   // Reset position, midway between the endpoints (integer floor).
   function automatic int center(input int pulse_min, input int pulse_max);
      return (pulse_min + pulse_max) / 2;
   endfunction

   // Width of the frame counter (0..period-1).
   function automatic int frame_w(input int period);
      return (period > 1) ? $clog2(period) : 1;
   endfunction

   // Width of a position register holding up to pulse_max.
   function automatic int pos_w(input int pulse_max);
      return $clog2(pulse_max + 1);
   endfunction

   // Width of the vote accumulator, which must hold a full frame of samples.
   function automatic int vote_w(input int period);
      return $clog2(period + 1);
   endfunction

   // Width of the clk-to-tick prescaler.
   function automatic int tick_w(input int tick_div);
      return (tick_div > 1) ? $clog2(tick_div) : 1;
   endfunction

endpackage

// File: rtl/rc_servo_core_n_if.sv
// rtl/rc_servo_core_n_if.sv - comparator/enable/PWM bundle between the servo core and its host
//
// Purpose: groups the per-channel comparator inputs, enables and PWM outputs
//          together with the frame marker.
// Ports:   comp_async_i [NUM_CH] asynchronous comparator inputs
//          ch_en_i      [NUM_CH] channel enables (taken at frame boundary)
//          pwm_o        [NUM_CH] registered servo PWM outputs
//          frame_o               one-clk frame-start pulse
// Modports: master = host side (drives comparators/enables), slave = core side.
interface rc_servo_core_n_if #(
   parameter int NUM_CH = 2
);
   logic [NUM_CH-1:0] comp_async_i;
   logic [NUM_CH-1:0] ch_en_i;
   logic [NUM_CH-1:0] pwm_o;
   logic              frame_o;

   modport master (
      output comp_async_i,
      output ch_en_i,
      input  pwm_o,
      input  frame_o
   );

   modport slave (
      input  comp_async_i,
      input  ch_en_i,
      output pwm_o,
      output frame_o
   );
endinterface

// File: rtl/rc_servo_core_n_chan.sv
// rtl/rc_servo_core_n_chan.sv - one servo channel: synchroniser, frame vote, position and PWM
//
// Purpose: tracks one asynchronous comparator input. A majority vote over each
//          frame steps the pulse width up or down by STEP_US (saturating, with
//          hold on an exact tie) and a registered PWM output is produced.
// Ports:   clk_i, reset_i   clock and synchronous active-high reset
//          tick             one-clk strobe per microsecond tick
//          boundary         tick that wraps the frame counter
//          frame_cnt        current tick index within the frame
//          comp_async       asynchronous comparator input
//          ch_en            channel enable request
//          pwm              registered PWM output
module rc_servo_chan
   import rc_servo_pkg::*;
#(
   parameter int PERIOD_US    = DEF_PERIOD_US,
   parameter int PULSE_MIN_US = DEF_PULSE_MIN_US,
   parameter int PULSE_MAX_US = DEF_PULSE_MAX_US,
   parameter int STEP_US      = DEF_STEP_US,
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int FRAME_W      = frame_w(DEF_PERIOD_US),
   parameter int POS_W        = pos_w(DEF_PULSE_MAX_US),
   parameter int VOTE_W       = vote_w(DEF_PERIOD_US)
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               tick,
   input  logic               boundary,
   input  logic [FRAME_W-1:0] frame_cnt,
   input  logic               comp_async,
   input  logic               ch_en,
   output logic               pwm
);

   localparam int CMP_W = (FRAME_W > POS_W) ? FRAME_W : POS_W;

   localparam logic [POS_W-1:0] POS_CENTER = POS_W'(center(PULSE_MIN_US, PULSE_MAX_US));
   localparam logic [POS_W-1:0] POS_MIN    = POS_W'(PULSE_MIN_US);
   localparam logic [POS_W-1:0] POS_MAX    = POS_W'(PULSE_MAX_US);
   localparam logic [POS_W-1:0] POS_STEP   = POS_W'(STEP_US);
   // Position arithmetic is one bit wider so pos+STEP never wraps before clamping.
   localparam logic [POS_W:0]   MIN_X      = (POS_W+1)'(PULSE_MIN_US);
   localparam logic [POS_W:0]   MAX_X      = (POS_W+1)'(PULSE_MAX_US);
   localparam logic [POS_W:0]   STEP_X     = (POS_W+1)'(STEP_US);
   localparam logic [VOTE_W:0]  PERIOD_X   = (VOTE_W+1)'(PERIOD_US);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   comp_s;
   logic [VOTE_W-1:0]      hi_cnt, hi_nxt, total;
   logic [POS_W-1:0]       pos, pos_nxt, pos_up_sat, pos_dn_sat;
   logic [POS_W:0]         pos_up;
   logic [VOTE_W:0]        twice_total;
   logic                   en_act, en_nxt;
   logic [FRAME_W-1:0]     frame_nxt;
   logic [CMP_W-1:0]       frame_cmp, pos_cmp;

   assign comp_s      = sync_q[SYNC_STAGES-1];
   assign total       = hi_cnt + VOTE_W'(comp_s);
   assign twice_total = {total, 1'b0};

   assign pos_up     = {1'b0, pos} + STEP_X;
   assign pos_up_sat = (pos_up > MAX_X) ? POS_MAX : pos_up[POS_W-1:0];
   assign pos_dn_sat = ({1'b0, pos} < (MIN_X + STEP_X)) ? POS_MIN : (pos - POS_STEP);

   // Frame index for the coming cycle; the PWM register is driven from the
   // next-state values so the pulse rises in the same cycle as frame_o.
   assign frame_nxt = boundary ? '0 : (tick ? frame_cnt + FRAME_W'(1) : frame_cnt);

   always_comb begin
      hi_nxt  = hi_cnt;
      pos_nxt = pos;
      en_nxt  = en_act;
      if (tick) begin
         if (boundary) begin
            hi_nxt = '0;
            en_nxt = ch_en;
            if (en_act) begin
               if (twice_total > PERIOD_X) begin
                  pos_nxt = pos_up_sat;
               end else if (twice_total < PERIOD_X) begin
                  pos_nxt = pos_dn_sat;
               end
            end
         end else begin
            hi_nxt = total;
         end
      end
   end

   assign frame_cmp = CMP_W'(frame_nxt);
   assign pos_cmp   = CMP_W'(pos_nxt);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync_q <= '0;
         hi_cnt <= '0;
         pos    <= POS_CENTER;
         en_act <= 1'b0;
         pwm    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], comp_async};
         hi_cnt <= hi_nxt;
         pos    <= pos_nxt;
         en_act <= en_nxt;
         pwm    <= en_nxt && (frame_cmp < pos_cmp);
      end
   end

endmodule

// File: rtl/rc_servo_core_n.sv
// rtl/rc_servo_core_n.sv - N-channel RC-servo tracking core with shared microsecond timebase
//
// Purpose: divides clk down to a microsecond tick, counts ticks into frames of
//          PERIOD_US, emits a one-clk frame_o pulse at each frame start and
//          drives NUM_CH independent rc_servo_chan instances.
// Ports:   clk_i    system clock
//          reset_i  synchronous active-high reset
//          bus      rc_servo_core_n_if slave: comp_async_i, ch_en_i in;
//                   pwm_o, frame_o out
module rc_servo_core_n
   import rc_servo_pkg::*;
#(
   parameter int NUM_CH       = DEF_NUM_CH,
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int PERIOD_US    = DEF_PERIOD_US,
   parameter int PULSE_MIN_US = DEF_PULSE_MIN_US,
   parameter int PULSE_MAX_US = DEF_PULSE_MAX_US,
   parameter int STEP_US      = DEF_STEP_US,
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
   input  logic         clk_i,
   input  logic         reset_i,
   rc_servo_core_n_if.slave bus
);

   localparam int TICK_W  = tick_w(TICK_DIV);
   localparam int FRAME_W = frame_w(PERIOD_US);
   localparam int POS_W   = pos_w(PULSE_MAX_US);
   localparam int VOTE_W  = vote_w(PERIOD_US);

   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(PERIOD_US - 1);

   logic [TICK_W-1:0]  tick_cnt;
   logic [FRAME_W-1:0] frame_cnt;
   logic               tick;
   logic               boundary;
   logic               frame_q;
   logic [NUM_CH-1:0]  pwm;

   assign tick     = (tick_cnt == TICK_LAST);
   assign boundary = tick && (frame_cnt == FRAME_LAST);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tick_cnt  <= '0;
         frame_cnt <= '0;
         frame_q   <= 1'b0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
         if (tick) begin
            frame_cnt <= boundary ? '0 : frame_cnt + FRAME_W'(1);
         end
         frame_q <= boundary;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      rc_servo_chan #(
         .PERIOD_US   (PERIOD_US),
         .PULSE_MIN_US(PULSE_MIN_US),
         .PULSE_MAX_US(PULSE_MAX_US),
         .STEP_US     (STEP_US),
         .SYNC_STAGES (SYNC_STAGES),
         .FRAME_W     (FRAME_W),
         .POS_W       (POS_W),
         .VOTE_W      (VOTE_W)
      ) u_chan (
         .clk_i     (clk_i),
         .reset_i   (reset_i),
         .tick      (tick),
         .boundary  (boundary),
         .frame_cnt (frame_cnt),
         .comp_async(bus.comp_async_i[i]),
         .ch_en     (bus.ch_en_i[i]),
         .pwm       (pwm[i])
      );
   end

   assign bus.pwm_o   = pwm;
   assign bus.frame_o = frame_q;

endmodule
